line_clear_sequencer: RTL
=========================

// Module: line_clear_sequencer
// PURPOSE
//  Runs the post-lock phase for one player's board. After the active tetromino locks, it scans the
//  board bottom-up, compacts out full rows, and clears the freed top rows to EMPTY. It then updates
//  score, total lines, level and level_speed. It holds board_busy high while working so the piece
//  logic freezes. One instance per player; it shares the board row port with the board writer.
// PARAMETERS
//  COLS            10  cells per row
//  ROWS            20  rows; row 0 = top
//  CELL_W          3   bits per cell; 0 = EMPTY
//  LINES_PER_LEVEL 10  total cleared lines per level step
//  MAX_LEVEL       15  level saturates here
//  BASE_SPEED      48  level_speed at level 0, in frames per drop
//  SPEED_STEP      3   level_speed decrement per level
//  MIN_SPEED       3   level_speed floor
// PORTS
//  Clk           in   1            system clock
//  Reset         in   1            synchronous, active-high
//  lock_req      in   1            1-cycle pulse: piece locked into the board
//  board_busy    out  1            high in every state except IDLE
//  row_rd_en     out  1            board row read strobe
//  row_wr_en     out  1            board row write strobe
//  row_addr      out  5            row index for read/write
//  row_rdata     in   COLS*CELL_W  read data, valid exactly 1 cycle after row_rd_en
//  row_wdata     out  COLS*CELL_W  write data
//  clear_done    out  1            1-cycle pulse when the sequence finishes
//  lines_cleared out  3            rows removed by the last sequence (0..4)
//  total_lines   out  10           saturating count of cleared rows
//  score         out  16           saturating score
//  level         out  4            min(total_lines / LINES_PER_LEVEL, MAX_LEVEL)
//  level_speed   out  6            max(BASE_SPEED - level*SPEED_STEP, MIN_SPEED)
// BEHAVIOUR
//  Reset: state=IDLE; all strobes, board_busy, clear_done, lines_cleared, total_lines, score,
//   level = 0; level_speed = BASE_SPEED; pending = 0.
//   Reset mid-sequence aborts at once: no further writes; board contents are not repaired.
//  Pointers: src, dst are 6-bit signed. Both are set to ROWS-1 on start.
//  FSM:
//   IDLE  - on lock_req (or pending): cnt=0, src=dst=ROWS-1, board_busy=1 next cycle -> READ
//   READ  - row_rd_en=1, row_addr=src -> CHECK
//   CHECK - sample row_rdata. Full = every CELL_W field nonzero.
//           full: cnt++, src--.
//           not full: if src!=dst then row_wr_en=1, row_addr=dst, row_wdata=row_rdata;
//                     then dst--, src--.
//           next state: src<0 after update -> FILL (if dst>=0) or SCORE; else -> READ
//   FILL  - row_wr_en=1, row_addr=dst, row_wdata=0, dst--; when dst<0 -> SCORE
//   SCORE - lines_cleared=cnt; total_lines+=cnt (sat 1023);
//           score += pts[cnt]*(level+1), pts={0,1,3,5,8}, sat 16'hFFFF;
//           level/level_speed use the OLD level this cycle -> LEVEL
//   LEVEL - recompute level, level_speed from the new total_lines -> DONE
//   DONE  - clear_done=1 for 1 cycle; board_busy drops next cycle -> IDLE
//  Only one of row_rd_en / row_wr_en is high in any cycle.
//  Latency, no clears: 2*ROWS+3 cycles from lock_req to clear_done (43 at ROWS=20).
//   Each cleared row adds 1 FILL cycle.
//  lock_req while not IDLE sets pending (one deep). IDLE services it next cycle. Extra requests
//   are dropped. lock_req in the same cycle as DONE also sets pending.
//  cnt cannot exceed 4 in legal play. If cnt>4, pts saturates at 8.
//  level_speed arithmetic is done at 8 bits, then clamped to MIN_SPEED.
//  Outputs other than the strobes hold their value between sequences.
// TESTING
//  1 Empty board, lock_req -> no writes, clear_done at +43 cycles, score 0, lines_cleared 0.
//  2 Row 19 full, row 18 partial P -> row 19 <= P, row 18 <= 0, rows 17..0 copied down,
//    lines_cleared 1, score 1.
//  3 Rows 16..19 full at level 2 -> 4 FILL writes of 0 to rows 3..0, score += 24,
//    total_lines 4.
//  4 total_lines 9 -> clear 1 row -> level 1, level_speed 45; at level 15, level_speed stays 3.
//  5 lock_req pulsed mid-READ, then a second pulse -> exactly one extra sequence runs after DONE.
//  6 Reset asserted during FILL -> next cycle IDLE, board_busy 0, no wr strobe, score 0.

Source files
------------

// File: rtl/line_clear_sequencer.sv
// Post-lock line-clear sequencer: compacts full rows out of the board bottom-up,
// blanks the freed top rows, then updates score, total lines, level and drop speed.
module line_clear_sequencer #(
  parameter int COLS            = 10,
  parameter int ROWS            = 20,
  parameter int CELL_W          = 3,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int BASE_SPEED      = 48,
  parameter int SPEED_STEP      = 3,
  parameter int MIN_SPEED       = 3
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     lock_req,
  output logic                     board_busy,
  output logic                     row_rd_en,
  output logic                     row_wr_en,
  output logic [4:0]               row_addr,
  input  logic [COLS*CELL_W-1:0]   row_rdata,
  output logic [COLS*CELL_W-1:0]   row_wdata,
  output logic                     clear_done,
  output logic [2:0]               lines_cleared,
  output logic [9:0]               total_lines,
  output logic [15:0]              score,
  output logic [3:0]               level,
  output logic [5:0]               level_speed
);

  localparam int ROW_W = COLS * CELL_W;

  typedef enum logic [2:0] {IDLE, READ, CHECK, FILL, SCORE, LEVEL, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [5:0]  src_q, src_d, dst_q, dst_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [2:0]         lines_cleared_q, lines_cleared_d;
  logic [9:0]         total_lines_q, total_lines_d;
  logic [15:0]        score_q, score_d;
  logic [3:0]         level_q, level_d;
  logic [5:0]         level_speed_q, level_speed_d;
  logic [8:0]         score_gain;

  function automatic logic row_full(input logic [ROW_W-1:0] r);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (r[c*CELL_W +: CELL_W] == '0) full = 1'b0;
    return full;
  endfunction

  // Clears beyond four only happen in illegal play; they earn the four-line value.
  function automatic logic [3:0] pts_for(input logic [4:0] c);
    case (c)
      5'd0:    return 4'd0;
      5'd1:    return 4'd1;
      5'd2:    return 4'd3;
      5'd3:    return 4'd5;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [8:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {8'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [9:0] sat_add10(input logic [9:0] a, input logic [4:0] b);
    logic [10:0] s;
    s = {1'b0, a} + {6'd0, b};
    return s[10] ? 10'h3FF : s[9:0];
  endfunction

  function automatic logic [3:0] level_for(input logic [9:0] t);
    logic [9:0] q;
    q = t / 10'(LINES_PER_LEVEL);
    return (q > 10'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : q[3:0];
  endfunction

  function automatic logic [5:0] speed_for(input logic [3:0] lvl);
    logic signed [7:0] s;
    s = 8'(BASE_SPEED - int'(lvl) * SPEED_STEP);
    if (s < $signed(8'(MIN_SPEED))) return 6'(MIN_SPEED);
    return s[5:0];
  endfunction

  assign score_gain = 9'(pts_for(cnt_q)) * 9'({1'b0, level_q} + 5'd1);

  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    dst_d           = dst_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    lines_cleared_d = lines_cleared_q;
    total_lines_d   = total_lines_q;
    score_d         = score_q;
    level_d         = level_q;
    level_speed_d   = level_speed_q;
    row_rd_en       = 1'b0;
    row_wr_en       = 1'b0;
    row_addr        = '0;
    row_wdata       = '0;

    if (lock_req && state_q != IDLE) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (lock_req || pending_q) begin
          cnt_d     = '0;
          src_d     = 6'(ROWS - 1);
          dst_d     = 6'(ROWS - 1);
          pending_d = 1'b0;
          state_d   = READ;
        end
      end
      READ: begin
        row_rd_en = 1'b1;
        row_addr  = src_q[4:0];
        state_d   = CHECK;
      end
      CHECK: begin
        if (row_full(row_rdata)) begin
          cnt_d = cnt_q + 5'd1;
        end else begin
          // A row that has not moved yet needs no write-back.
          if (src_q != dst_q) begin
            row_wr_en = 1'b1;
            row_addr  = dst_q[4:0];
            row_wdata = row_rdata;
          end
          dst_d = dst_q - 6'sd1;
        end
        src_d = src_q - 6'sd1;
        if (src_d[5]) state_d = dst_d[5] ? SCORE : FILL;
        else          state_d = READ;
      end
      FILL: begin
        row_wr_en = 1'b1;
        row_addr  = dst_q[4:0];
        dst_d     = dst_q - 6'sd1;
        if (dst_d[5]) state_d = SCORE;
      end
      SCORE: begin
        lines_cleared_d = (cnt_q > 5'd7) ? 3'd7 : cnt_q[2:0];
        total_lines_d   = sat_add10(total_lines_q, cnt_q);
        score_d         = sat_add16(score_q, score_gain);
        state_d         = LEVEL;
      end
      LEVEL: begin
        level_d       = level_for(total_lines_q);
        level_speed_d = speed_for(level_d);
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= IDLE;
      src_q           <= '0;
      dst_q           <= '0;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      lines_cleared_q <= '0;
      total_lines_q   <= '0;
      score_q         <= '0;
      level_q         <= '0;
      level_speed_q   <= 6'(BASE_SPEED);
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      dst_q           <= dst_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      lines_cleared_q <= lines_cleared_d;
      total_lines_q   <= total_lines_d;
      score_q         <= score_d;
      level_q         <= level_d;
      level_speed_q   <= level_speed_d;
    end
  end

  assign board_busy    = (state_q != IDLE);
  assign clear_done    = (state_q == DONE);
  assign lines_cleared = lines_cleared_q;
  assign total_lines   = total_lines_q;
  assign score         = score_q;
  assign level         = level_q;
  assign level_speed   = level_speed_q;

endmodule
